// File: rtl/pop_counter_bank_if.sv
// Pop-counter bank bus: per-channel pop strobes in, idle-gated indexed readout out.
interface pop_counter_bank_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 5
);
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] pop;
   logic              idle;
   logic              req;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  data_out;
   logic              ovf_out;
   logic              valid;
   logic              rd_err;

   modport master (
      output pop, idle, req, idx,
      input  data_out, ovf_out, valid, rd_err
   );

   modport slave (
      input  pop, idle, req, idx,
      output data_out, ovf_out, valid, rd_err
   );
endinterface

// File: rtl/pop_counter_bank.sv
// Bank of per-channel FIFO pop counters with sticky overflow flags and a
// registered, idle-gated, index-addressed readout (latency 1).
module pop_counter_bank #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 5,
   parameter bit          SATURATE    = 1'b0,
   parameter bit          CLR_ON_READ = 1'b0
) (
   input logic               clk,
   input logic               reset_L,
   pop_counter_bank_if.slave bus
);
   localparam int unsigned      IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W:0]   NUM_CH_X = (IDX_W+1)'(NUM_CH);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] ovf_q, ovf_d;

   logic [CNT_W-1:0]  data_q, data_d;
   logic              ovf_out_q, ovf_out_d;
   logic              valid_q, valid_d;
   logic              rd_err_q, rd_err_d;

   logic              rd_acc;
   logic              rd_hit;
   logic [CNT_W-1:0]  rd_cnt;
   logic              rd_ovf;

   assign rd_acc = bus.idle & bus.req;
   assign rd_hit = rd_acc & ({1'b0, bus.idx} < NUM_CH_X);

   always_comb begin
      rd_cnt = '0;
      rd_ovf = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (bus.idx == IDX_W'(i)) begin
            rd_cnt = cnt_q[i];
            rd_ovf = ovf_q[i];
         end
      end
   end

   // Clear-on-read wins over the count, but a same-cycle pop still lands as 1.
   always_comb begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i];
         if (bus.pop[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = SATURATE ? CNT_MAX : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
         if (CLR_ON_READ && rd_hit && (bus.idx == IDX_W'(i))) begin
            cnt_d[i] = bus.pop[i] ? CNT_W'(1) : '0;
            ovf_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      data_d    = '0;
      ovf_out_d = 1'b0;
      valid_d   = 1'b0;
      rd_err_d  = 1'b0;
      if (rd_acc) begin
         valid_d = 1'b1;
         if (rd_hit) begin
            data_d    = rd_cnt;
            ovf_out_d = rd_ovf;
         end else begin
            rd_err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
         ovf_q     <= '0;
         data_q    <= '0;
         ovf_out_q <= 1'b0;
         valid_q   <= 1'b0;
         rd_err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
         ovf_q     <= ovf_d;
         data_q    <= data_d;
         ovf_out_q <= ovf_out_d;
         valid_q   <= valid_d;
         rd_err_q  <= rd_err_d;
      end
   end

   assign bus.data_out = data_q;
   assign bus.ovf_out  = ovf_out_q;
   assign bus.valid    = valid_q;
   assign bus.rd_err   = rd_err_q;
endmodule
